// File: rtl/input_debouncer_if.sv
// rtl/input_debouncer_if.sv - raw input and debounced outputs of the input debouncer
interface input_debouncer_if;
    logic d_raw;
    logic d;
    logic db;
    logic rise;
    logic fall;
    logic busy;

    modport master (
        output d_raw,
        input  d,
        input  db,
        input  rise,
        input  fall,
        input  busy
    );

    modport slave (
        input  d_raw,
        output d,
        output db,
        output rise,
        output fall,
        output busy
    );
endinterface

// File: rtl/input_debouncer.sv
// rtl/input_debouncer.sv - synchroniser plus 4-state debounce FSM producing d, ~d and edge pulses
module input_debouncer #(
    parameter int   SYNC_STAGES   = 2,
    parameter int   STABLE_CYCLES = 4,
    parameter logic INIT_LEVEL    = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    input_debouncer_if.slave   bus
);
    localparam int CNT_W = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE_LO = 2'd0,
        WAIT_HI = 2'd1,
        IDLE_HI = 2'd2,
        WAIT_LO = 2'd3
    } state_t;

    localparam state_t RESET_STATE = INIT_LEVEL ? IDLE_HI : IDLE_LO;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;
    state_t                 state, state_n;
    logic [CNT_W-1:0]       cnt, cnt_n;
    logic                   d_q, d_n;
    logic                   db_q;
    logic                   rise_q, rise_n;
    logic                   fall_q, fall_n;
    logic                   busy_q, busy_n;

    // The FSM only ever looks at the last synchroniser stage.
    assign sync = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{INIT_LEVEL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.d_raw};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= RESET_STATE;
            cnt    <= '0;
            d_q    <= INIT_LEVEL;
            db_q   <= ~INIT_LEVEL;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            d_q    <= d_n;
            db_q   <= ~d_n;
            rise_q <= rise_n;
            fall_q <= fall_n;
            busy_q <= busy_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        d_n     = d_q;
        rise_n  = 1'b0;
        fall_n  = 1'b0;
        case (state)
            IDLE_LO: begin
                if (sync) begin
                    state_n = WAIT_HI;
                    cnt_n   = '0;
                end
            end
            WAIT_HI: begin
                if (!sync) begin
                    state_n = IDLE_LO;
                    cnt_n   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_n = IDLE_HI;
                    cnt_n   = '0;
                    d_n     = 1'b1;
                    rise_n  = 1'b1;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            IDLE_HI: begin
                if (!sync) begin
                    state_n = WAIT_LO;
                    cnt_n   = '0;
                end
            end
            WAIT_LO: begin
                if (sync) begin
                    state_n = IDLE_HI;
                    cnt_n   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_n = IDLE_LO;
                    cnt_n   = '0;
                    d_n     = 1'b0;
                    fall_n  = 1'b1;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_n = RESET_STATE;
                cnt_n   = '0;
            end
        endcase
        busy_n = (state_n == WAIT_HI) || (state_n == WAIT_LO);
    end

    assign bus.d    = d_q;
    assign bus.db   = db_q;
    assign bus.rise = rise_q;
    assign bus.fall = fall_q;
    assign bus.busy = busy_q;
endmodule

// File: tb/tb_input_debouncer.sv
// tb/tb_input_debouncer.sv - randomized and directed scoreboard bench for input_debouncer
module tb_input_debouncer;
    localparam int   SYNC   = 2;
    localparam int   STABLE = 4;
    localparam logic INIT   = 1'b0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   cycle = 0;

    input_debouncer_if bus();

    input_debouncer #(
        .SYNC_STAGES  (SYNC),
        .STABLE_CYCLES(STABLE),
        .INIT_LEVEL   (INIT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Expected {d, db, rise, fall, busy} per clock edge
    logic [4:0] exp_q[$];

    // Reference: input seen by the debouncer is d_raw delayed SYNC edges; d flips
    // once the seen value has differed from d for STABLE+1 consecutive edges.
    logic line[$];
    logic d_m = INIT;
    int   run = 0;

    initial begin
        for (int i = 0; i < SYNC; i++) line.push_back(INIT);
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                line.delete();
                for (int i = 0; i < SYNC; i++) line.push_back(INIT);
                d_m = INIT;
                run = 0;
                exp_q.delete();
            end else begin
                logic seen;
                logic r, f;
                seen = line.pop_front();
                line.push_back(bus.d_raw);
                r = 1'b0;
                f = 1'b0;
                if (seen != d_m) begin
                    run++;
                    if (run == STABLE + 1) begin
                        d_m = seen;
                        r = seen;
                        f = ~seen;
                        run = 0;
                    end
                end else begin
                    run = 0;
                end
                exp_q.push_back({d_m, ~d_m, r, f, (run > 0)});
            end
        end
    end

    // Monitor: every edge the DUT presents a fresh output word
    initial begin
        forever begin
            @(posedge clk);
            cycle++;
            #1;
            if (!rst_n) begin
                checks++;
                if ({bus.d, bus.db, bus.rise, bus.fall, bus.busy} !== {INIT, ~INIT, 3'b000}) begin
                    errors++;
                    $display("FAIL reset_out cycle=%0d got=%b exp=%b", cycle,
                             {bus.d, bus.db, bus.rise, bus.fall, bus.busy}, {INIT, ~INIT, 3'b000});
                end
            end else if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_underflow cycle=%0d got=empty exp=entry", cycle);
            end else begin
                logic [4:0] e;
                e = exp_q.pop_front();
                checks++;
                if ({bus.d, bus.db, bus.rise, bus.fall, bus.busy} !== e) begin
                    errors++;
                    $display("FAIL out cycle=%0d got=%b exp=%b (d,db,rise,fall,busy)", cycle,
                             {bus.d, bus.db, bus.rise, bus.fall, bus.busy}, e);
                end
            end
        end
    end

    task automatic hold(input logic v, input int n);
        repeat (n) begin
            @(negedge clk);
            bus.d_raw = v;
        end
    endtask

    initial begin
        bus.d_raw = 1'b1;
        rst_n = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;

        // Power-up with d_raw already high, then falling, clean step, glitch
        hold(1'b1, 12);
        hold(1'b0, 12);
        hold(1'b1, 12);
        hold(1'b0, 12);
        hold(1'b1, 3);
        hold(1'b0, 12);

        // Bounce train then settle high
        hold(1'b1, 1);
        hold(1'b0, 1);
        hold(1'b1, 1);
        hold(1'b0, 1);
        hold(1'b1, 12);

        // Bounce train then settle low, and accepted change followed by instant new transition
        hold(1'b0, 1);
        hold(1'b1, 1);
        hold(1'b0, 7);
        hold(1'b1, 10);

        // Randomised run lengths straddling the acceptance threshold
        repeat (80) begin
            logic v;
            int   n;
            v = 1'(($urandom_range(0, 1)));
            n = $urandom_range(1, 8);
            hold(v, n);
        end

        // Asynchronous reset while a count is in progress
        hold(1'b0, 12);
        @(negedge clk);
        bus.d_raw = 1'b1;
        for (int i = 0; i < 20 && !bus.busy; i++) @(negedge clk);
        checks++;
        if (!bus.busy) begin
            errors++;
            $display("FAIL busy_wait_timeout got=%b exp=1", bus.busy);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.d, bus.busy, bus.rise} !== {INIT, 2'b00}) begin
            errors++;
            $display("FAIL async_reset_abort got=%b exp=%b (d,busy,rise)",
                     {bus.d, bus.busy, bus.rise}, {INIT, 2'b00});
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        hold(1'b1, 12);

        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/input_debouncer.md
Name: input_debouncer

Overview:
- Upstream conditioning stage for the D flip-flop bank. It takes an asynchronous, bouncy raw input such as a switch or button and produces a clean, synchronised data level `d` that feeds the flip-flop `d` pin, plus its complement.
- It also produces single-cycle rise/fall event pulses for downstream counters.
- Internal structure: a multi-stage synchroniser, then a 4-state debounce FSM with a stability counter.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops on d_raw (legal range 2..4).
- STABLE_CYCLES, 4, consecutive clk cycles the synchronised input must hold the new level before d changes (legal minimum 2).
- INIT_LEVEL, 0, reset value of the synchroniser flops, of d, and the IDLE state entered at reset.

Ports:
- clk  input  1  rising-edge clock; all state changes on posedge clk.
- rst_n  input  1  asynchronous, active-low reset.
- d_raw  input  1  raw asynchronous level (may bounce).
- d  output  1  debounced, synchronised level; drives the flip-flop d input.
- db  output  1  always ~d (registered alongside d, never combinational from d_raw).
- rise  output  1  one-cycle pulse, coincident with d going 0->1.
- fall  output  1  one-cycle pulse, coincident with d going 1->0.
- busy  output  1  high while the FSM is in a WAIT state.

Behaviour:
- Reset (rst_n=0, asynchronous, takes effect immediately mid-cycle):
  - all synchroniser flops = INIT_LEVEL; d = INIT_LEVEL; db = ~INIT_LEVEL.
  - rise = fall = busy = 0; counter = 0.
  - state = IDLE_HI if INIT_LEVEL else IDLE_LO.
- Reset release is synchronous to the next posedge; no output changes on the release edge itself.
- Synchroniser: a SYNC_STAGES-deep shift chain; `sync` is the last stage. The FSM only ever sees `sync`, never d_raw.
- Counter: width = clog2(STABLE_CYCLES), computed internally; it never wraps.
- FSM states and transitions:
  - IDLE_LO (d=0): if sync=1 -> WAIT_HI with cnt=0; else stay.
  - WAIT_HI: if sync=0 -> IDLE_LO, cnt=0, no pulse (bounce rejected). Else if cnt==STABLE_CYCLES-1 -> IDLE_HI with d<=1, db<=0, rise<=1. Else cnt<=cnt+1.
  - IDLE_HI (d=1): if sync=0 -> WAIT_LO with cnt=0; else stay.
  - WAIT_LO: mirror of WAIT_HI; completion sets d<=0, db<=1, fall<=1.
- Latency: if d_raw is sampled at a new level at edge N and held, d changes at edge N+SYNC_STAGES+STABLE_CYCLES (6 with defaults).
  - Acceptance requires the sampled d_raw to be stable from edge N through edge N+STABLE_CYCLES inclusive.
- Outputs d, db, rise, fall and busy are all registered.
- rise/fall:
  - high for exactly one cycle, on the same edge that d changes.
  - never both high.
  - never asserted without a d change.
- busy = 1 exactly while the state is WAIT_HI or WAIT_LO.
- A bounce that returns to the current level before STABLE_CYCLES completes:
  - produces no change on d/db/rise/fall.
  - busy drops the cycle after sync reverts.
- A new transition arriving in IDLE immediately after an accepted change starts a fresh count; there is no hold-off beyond the count itself.
- Asynchronous reset asserted during WAIT aborts the count; there is no pulse, and d returns to INIT_LEVEL.

Test Plan:
1. Reset with INIT_LEVEL=0, d_raw=1 while rst_n=0 -> d=0, db=1, rise=fall=busy=0 throughout reset. Release reset with d_raw=1 held -> d=1 at the 6th posedge after release, with rise=1 for one cycle.
2. Clean step, defaults: after reset, hold d_raw=0 for 10 cycles, then d_raw=1 from edge 20.
   - busy=1 from edge 22.
   - d=1, db=0, rise=1 at edge 26; rise=0 and busy=0 at edge 27.
   - fall stays 0 throughout.
3. Glitch rejection: d_raw=1 for 3 cycles (edges 20..22), then 0.
   - d stays 0; rise stays 0.
   - busy=1 for 3 cycles, then 0.
4. Falling edge from d=1: d_raw=0 at edge N -> d=0, db=1, fall=1 at edge N+6 for one cycle; rise stays 0.
5. Bounce train: d_raw toggles 1,0,1,0,1 on consecutive edges, then holds 1.
   - exactly one rise pulse, occurring 6 edges after the final 0->1 sample.
   - d changes only once.
6. Reset mid-count: start a 0->1 step, assert rst_n=0 asynchronously when busy=1 (between clock edges) -> busy=0 and d=0 immediately, with no rise pulse. After release with d_raw still 1 -> a full 6-cycle count occurs before d=1.
